// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter: shares the PWM register bus between the I2C slave bridge
// (port 0) and an internal requester (port 1). Transactions are serialised:
// IDLE -> ISSUE -> (WAIT, reads) -> ACK -> IDLE.
//
// Ports:
//   clk_i, rst_n_i            PWM-domain clock, async active-low reset
//   mX_req_i/we_i/addr_i/wdata_i  request, direction, address, write data
//   mX_ack_o, mX_rdata_o      one-cycle completion pulse, held read data
//   addr_o, wdata_o           register bus address / write data (held)
//   wr_en_o, rd_en_o          single-cycle strobes (ISSUE state only)
//   rdata_i                   register bus read data, RD_LATENCY edges late
//   busy_o, grant_o           not-IDLE flag, index of current/last grant
//
// Build option: PWM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins);
// otherwise a 1-bit round-robin pointer alternates between contenders.
module pwm_reg_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic          wr_en_o,
    output logic          rd_en_o,
    input  logic [DW-1:0] rdata_i,
    output logic          busy_o,
    output logic          grant_o
);

    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_en_q, rd_en_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          busy_q, busy_d;
    logic          win_c;
    logic          sel_we_c;

`ifdef PWM_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it requests; port 1 only when alone.
    assign win_c = ~m0_req_i;
`else
    logic ptr_q, ptr_d;
    logic grant_fire_c;

    // Pointer names the preferred port on contention; flips after each grant.
    assign win_c        = (m0_req_i & m1_req_i) ? ptr_q : m1_req_i;
    assign grant_fire_c = (state_q == S_IDLE) & (m0_req_i | m1_req_i);
    assign ptr_d        = grant_fire_c ? ~win_c : ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end
`endif

    assign sel_we_c = win_c ? m1_we_i : m0_we_i;

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 1'b0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            busy_q     <= busy_d;
        end
    end

    // Next state; strobes/acks are computed one edge early so they leave flops
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (m0_req_i | m1_req_i) begin
                    state_d = S_ISSUE;
                    grant_d = win_c;
                    we_d    = sel_we_c;
                    addr_d  = win_c ? m1_addr_i  : m0_addr_i;
                    wdata_d = win_c ? m1_wdata_i : m0_wdata_i;
                    wr_en_d = sel_we_c;
                    rd_en_d = ~sel_we_c;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d  = S_ACK;
                    m0_ack_d = ~grant_q;
                    m1_ack_d = grant_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = S_ACK;
                    m0_ack_d = ~grant_q;
                    m1_ack_d = grant_q;
                    if (grant_q) m1_rdata_d = rdata_i;
                    else         m0_rdata_d = rdata_i;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign wr_en_o    = wr_en_q;
    assign rd_en_o    = rd_en_q;
    assign m0_ack_o   = m0_ack_q;
    assign m1_ack_o   = m1_ack_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
    assign busy_o     = busy_q;
    assign grant_o    = grant_q;

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
`timescale 1ns/1ps
module tb_pwm_reg_arbiter;

    localparam int RDL = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RD_LATENCY = 1)
    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [7:0]  m0_addr, m1_addr, addr;
    logic [15:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, wdata, rdata;
    logic        wr_en, rd_en, busy, grant;

    // Second DUT (RD_LATENCY = 3)
    logic        l3_m0_req, l3_m0_we, l3_m0_ack, l3_m1_ack;
    logic [7:0]  l3_m0_addr, l3_addr;
    logic [15:0] l3_m0_rdata, l3_m1_rdata, l3_wdata, l3_rdata;
    logic        l3_wr_en, l3_rd_en, l3_busy, l3_grant;

    pwm_reg_arbiter #(.AW(8), .DW(16), .RD_LATENCY(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
        .addr_o(addr), .wdata_o(wdata), .wr_en_o(wr_en), .rd_en_o(rd_en),
        .rdata_i(rdata), .busy_o(busy), .grant_o(grant)
    );

    pwm_reg_arbiter #(.AW(8), .DW(16), .RD_LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(l3_m0_req), .m0_we_i(l3_m0_we), .m0_addr_i(l3_m0_addr), .m0_wdata_i(16'h0000),
        .m0_ack_o(l3_m0_ack), .m0_rdata_o(l3_m0_rdata),
        .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(8'h00), .m1_wdata_i(16'h0000),
        .m1_ack_o(l3_m1_ack), .m1_rdata_o(l3_m1_rdata),
        .addr_o(l3_addr), .wdata_o(l3_wdata), .wr_en_o(l3_wr_en), .rd_en_o(l3_rd_en),
        .rdata_i(l3_rdata), .busy_o(l3_busy), .grant_o(l3_grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-schedule model: each accepted request occupies a window of
    // edges; strobe, ack and capture edges follow directly from start edge.
    int          e = 0;
    bit          act = 1'b0;
    int          t_s = 0, t_ack = 0;
    bit          t_we = 1'b0, t_w = 1'b0, ptr = 1'b0;
    logic [7:0]  x_addr = 8'h00;
    logic [15:0] x_wdata = 16'h0000;
    logic [15:0] x_rd [2];
    bit          x_grant = 1'b0;

    initial begin
        bit w;
        x_rd[0] = 16'h0000;
        x_rd[1] = 16'h0000;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                act = 1'b0; ptr = 1'b0; x_grant = 1'b0;
                x_addr = 8'h00; x_wdata = 16'h0000;
                x_rd[0] = 16'h0000; x_rd[1] = 16'h0000;
            end else begin
                e++;
                if (!act) begin
                    if (m0_req || m1_req) begin
`ifdef PWM_ARB_FIXED_PRIO_EN
                        w = !m0_req;
`else
                        w = (m0_req && m1_req) ? ptr : m1_req;
`endif
                        ptr     = !w;
                        act     = 1'b1;
                        t_w     = w;
                        t_s     = e;
                        t_we    = w ? m1_we : m0_we;
                        t_ack   = t_we ? e + 1 : e + 1 + RDL;
                        x_grant = w;
                        x_addr  = w ? m1_addr : m0_addr;
                        x_wdata = w ? m1_wdata : m0_wdata;
                    end
                end else begin
                    if (!t_we && e == t_ack) x_rd[t_w] = rdata;
                    if (e == t_ack + 1) act = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of the main DUT against the model
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_wr_en", 32'(wr_en), 32'(act && e == t_s && t_we));
            check("cyc_rd_en", 32'(rd_en), 32'(act && e == t_s && !t_we));
            check("cyc_m0_ack", 32'(m0_ack), 32'(act && e == t_ack && !t_w));
            check("cyc_m1_ack", 32'(m1_ack), 32'(act && e == t_ack && t_w));
            check("cyc_busy", 32'(busy), 32'(act));
            check("cyc_grant", 32'(grant), 32'(x_grant));
            check("cyc_addr", 32'(addr), 32'(x_addr));
            check("cyc_wdata", 32'(wdata), 32'(x_wdata));
            check("cyc_m0_rdata", 32'(m0_rdata), 32'(x_rd[0]));
            check("cyc_m1_rdata", 32'(m1_rdata), 32'(x_rd[1]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got_ack;
        logic gseq [4];
        logic eseq [4];

        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        rdata = 16'h0BAD;
        l3_m0_req = 0; l3_m0_we = 0; l3_m0_addr = 0; l3_rdata = 16'hDEAD;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_l3_busy", 32'(l3_busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // RD_LATENCY=3 read: only data present just before edge N+4 is taken
        l3_m0_req = 1; l3_m0_we = 0; l3_m0_addr = 8'h33;
        @(negedge clk);
        check("l3_rd_en", 32'(l3_rd_en), 32'd1);
        check("l3_addr", 32'(l3_addr), 32'h33);
        @(negedge clk);
        check("l3_wait1_rd_en", 32'(l3_rd_en), 32'd0);
        check("l3_wait1_ack", 32'(l3_m0_ack), 32'd0);
        check("l3_wait1_busy", 32'(l3_busy), 32'd1);
        @(negedge clk);
        check("l3_wait2_ack", 32'(l3_m0_ack), 32'd0);
        @(negedge clk);
        check("l3_wait3_ack", 32'(l3_m0_ack), 32'd0);
        l3_rdata = 16'h5A5A;
        @(negedge clk);
        check("l3_ack", 32'(l3_m0_ack), 32'd1);
        check("l3_rdata", 32'(l3_m0_rdata), 32'h5A5A);
        l3_rdata = 16'hDEAD; l3_m0_req = 0;
        @(negedge clk);
        check("l3_ack_done", 32'(l3_m0_ack), 32'd0);
        check("l3_idle", 32'(l3_busy), 32'd0);
        check("l3_rdata_hold", 32'(l3_m0_rdata), 32'h5A5A);

        // Port 0 write
        m0_req = 1; m0_we = 1; m0_addr = 8'h10; m0_wdata = 16'h1234;
        @(negedge clk);
        check("t1_wr_en", 32'(wr_en), 32'd1);
        check("t1_addr", 32'(addr), 32'h10);
        check("t1_wdata", 32'(wdata), 32'h1234);
        check("t1_ack_early", 32'(m0_ack), 32'd0);
        @(negedge clk);
        check("t1_m0_ack", 32'(m0_ack), 32'd1);
        check("t1_m1_ack", 32'(m1_ack), 32'd0);
        check("t1_wr_off", 32'(wr_en), 32'd0);
        m0_req = 0;
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);

        // Port 1 read, data valid only on the capture cycle
        m1_req = 1; m1_we = 0; m1_addr = 8'h22;
        @(negedge clk);
        check("t2_rd_en", 32'(rd_en), 32'd1);
        check("t2_addr", 32'(addr), 32'h22);
        check("t2_grant", 32'(grant), 32'd1);
        @(negedge clk);
        check("t2_ack_early", 32'(m1_ack), 32'd0);
        rdata = 16'hBEEF;
        @(negedge clk);
        check("t2_m1_ack", 32'(m1_ack), 32'd1);
        check("t2_m1_rdata", 32'(m1_rdata), 32'hBEEF);
        check("t2_m0_rdata", 32'(m0_rdata), 32'h0000);
        rdata = 16'h0BAD; m1_req = 0;
        @(negedge clk);

        // Both ports request continuously
        m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 16'h0040;
        m1_req = 1; m1_we = 1; m1_addr = 8'h41; m1_wdata = 16'h0041;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (wr_en) begin
                gseq[n] = grant;
                n++;
                if (n == 4) begin
                    m0_req = 0; m1_req = 0;
                end
            end
        end
        check("t3_grant_count", 32'(n), 32'd4);
`ifdef PWM_ARB_FIXED_PRIO_EN
        eseq[0] = 0; eseq[1] = 0; eseq[2] = 0; eseq[3] = 0;
`else
        eseq[0] = 0; eseq[1] = 1; eseq[2] = 0; eseq[3] = 1;
`endif
        for (int i = 0; i < 4; i++)
            if (i < n) check($sformatf("t3_grant%0d", i), 32'(gseq[i]), 32'(eseq[i]));
        m0_req = 0; m1_req = 0;
        repeat (4) @(negedge clk);

        // Port 0 drops req in the ISSUE cycle
        m0_req = 1; m0_we = 1; m0_addr = 8'h55; m0_wdata = 16'hA5A5;
        @(negedge clk);
        check("t4_wr_en", 32'(wr_en), 32'd1);
        m0_req = 0;
        @(negedge clk);
        check("t4_m0_ack", 32'(m0_ack), 32'd1);
        @(negedge clk);
        check("t4_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("t4_no_new", 32'(busy), 32'd0);
        check("t4_no_strobe", 32'(wr_en), 32'd0);

        // Reset during WAIT, request held through reset
        m1_req = 1; m1_we = 0; m1_addr = 8'h66; rdata = 16'h7777;
        @(negedge clk);
        check("t5_rd_en", 32'(rd_en), 32'd1);
        @(negedge clk);
        check("t5_in_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ack", 32'(m1_ack), 32'd0);
        check("t5_rst_addr", 32'(addr), 32'd0);
        check("t5_rst_rdata", 32'(m1_rdata), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_rst_hold_ack", 32'(m1_ack), 32'd0);
        #2 rst_n = 1'b1;
        got_ack = 0;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clk);
            if (m1_ack) got_ack = 1;
        end
        check("t5_new_ack", 32'(got_ack), 32'd1);
        check("t5_new_rdata", 32'(m1_rdata), 32'h7777);
        check("t5_new_addr", 32'(addr), 32'h66);
        m1_req = 0;
        repeat (3) @(negedge clk);
        check("t5_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
